// File: rtl/traffic_pkg.sv
// Shared state and light encodings for the intersection phase controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    S_ALLRED = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2
  } state_t;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b10;

endpackage

// File: rtl/second_prescaler.sv
// Divides the system clock down to a one-cycle pulse per elapsed second.
module second_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (!hold) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A frozen count must not keep re-firing the same second.
  assign tick = (count_q == LAST) && !hold;

endmodule

// File: rtl/traffic_phase_controller.sv
// Round-robin N-approach signal sequencer with green extension, latched
// pedestrian requests and emergency preemption.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int N_PHASES      = 2,
  parameter int PH_W          = $clog2(N_PHASES),
  parameter int TICK_DIV      = 50000000,
  parameter int GREEN_SEC     = 10,
  parameter int EXT_SEC       = 5,
  parameter int YELLOW_SEC    = 3,
  parameter int ALLRED_SEC    = 1,
  parameter int COUNTDOWN_SEC = 5,
  parameter int CNT_W         = 5
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic [N_PHASES-1:0]   ext_req,
  input  logic [N_PHASES-1:0]   ped_req,
  input  logic                  preempt_valid,
  input  logic [PH_W-1:0]       preempt_phase,
  output logic [2*N_PHASES-1:0] light,
  output logic [N_PHASES-1:0]   walk,
  output logic [N_PHASES-1:0]   countdown,
  output logic [CNT_W-1:0]      seconds_left,
  output logic [PH_W-1:0]       cur_phase,
  output logic                  tick
);

  localparam logic [CNT_W-1:0] GREEN_LEN     = CNT_W'(GREEN_SEC);
  localparam logic [CNT_W-1:0] GREEN_EXT_LEN = CNT_W'(GREEN_SEC + EXT_SEC);
  localparam logic [CNT_W-1:0] YELLOW_LEN    = CNT_W'(YELLOW_SEC);
  localparam logic [CNT_W-1:0] ALLRED_LEN    = CNT_W'(ALLRED_SEC);
  localparam logic [CNT_W-1:0] CD_LEN        = CNT_W'(COUNTDOWN_SEC);
  localparam logic [CNT_W-1:0] ONE_SEC       = CNT_W'(1);
  localparam logic [PH_W-1:0]  LAST_PH       = PH_W'(N_PHASES - 1);
  localparam logic [PH_W:0]    N_PH          = (PH_W + 1)'(N_PHASES);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    secs_q, secs_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [N_PHASES-1:0] ped_pend_q, ped_pend_d;
  logic                ped_active_q, ped_active_d;

  logic                preempt_ok;
  logic                preempt_other;
  logic                preempt_hold;
  logic                trans;
  logic                tick_w;
  logic [PH_W-1:0]     next_phase;
  logic [CNT_W-1:0]    green_len;

  // Out-of-range preemption targets are treated as no request at all.
  assign preempt_ok    = preempt_valid && ({1'b0, preempt_phase} < N_PH);
  assign preempt_other = (state_q == S_GREEN) && preempt_ok && (preempt_phase != phase_q);
  assign preempt_hold  = (state_q == S_GREEN) && preempt_ok && (preempt_phase == phase_q);

  assign next_phase = preempt_ok ? preempt_phase
                    : ((phase_q == LAST_PH) ? '0 : phase_q + 1'b1);
  assign green_len  = ext_req[next_phase] ? GREEN_EXT_LEN : GREEN_LEN;

  second_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clear  (trans),
    .hold   (preempt_hold),
    .tick   (tick_w)
  );

  always_comb begin
    state_d      = state_q;
    secs_d       = secs_q;
    phase_d      = phase_q;
    ped_pend_d   = ped_pend_q | ped_req;
    ped_active_d = ped_active_q;
    trans        = 1'b0;
    case (state_q)
      S_GREEN: begin
        // Preemption wins over a coincident expiry; both land in YELLOW.
        if (preempt_other) begin
          state_d      = S_YELLOW;
          secs_d       = YELLOW_LEN;
          ped_active_d = 1'b0;
          trans        = 1'b1;
        end else if (tick_w) begin
          if (secs_q == ONE_SEC) begin
            state_d      = S_YELLOW;
            secs_d       = YELLOW_LEN;
            ped_active_d = 1'b0;
            trans        = 1'b1;
          end else begin
            secs_d = secs_q - 1'b1;
          end
        end
      end
      S_YELLOW: begin
        if (tick_w) begin
          if (secs_q == ONE_SEC) begin
            state_d = S_ALLRED;
            secs_d  = ALLRED_LEN;
            trans   = 1'b1;
          end else begin
            secs_d = secs_q - 1'b1;
          end
        end
      end
      S_ALLRED: begin
        if (tick_w) begin
          if (secs_q == ONE_SEC) begin
            state_d      = S_GREEN;
            phase_d      = next_phase;
            secs_d       = green_len;
            ped_active_d = ped_pend_q[next_phase];
            // A request landing on the entry edge waits for the next service.
            ped_pend_d[next_phase] = ped_req[next_phase];
            trans        = 1'b1;
          end else begin
            secs_d = secs_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = S_ALLRED;
        secs_d  = ALLRED_LEN;
        trans   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= S_ALLRED;
      secs_q       <= ALLRED_LEN;
      phase_q      <= LAST_PH;
      ped_pend_q   <= '0;
      ped_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      secs_q       <= secs_d;
      phase_q      <= phase_d;
      ped_pend_q   <= ped_pend_d;
      ped_active_q <= ped_active_d;
    end
  end

  always_comb begin
    light     = '0;
    walk      = '0;
    countdown = '0;
    for (int i = 0; i < N_PHASES; i++) begin
      light[2*i +: 2] = LIGHT_RED;
      if (phase_q == PH_W'(i)) begin
        if (state_q == S_GREEN) begin
          light[2*i +: 2] = LIGHT_GREEN;
          walk[i]         = ped_active_q && (secs_q > CD_LEN);
          countdown[i]    = ped_active_q && (secs_q <= CD_LEN);
        end else if (state_q == S_YELLOW) begin
          light[2*i +: 2] = LIGHT_YELLOW;
        end
      end
    end
  end

  assign seconds_left = secs_q;
  assign cur_phase    = phase_q;
  assign tick         = tick_w;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller with three approaches and a
// four-cycle second.
module tb_traffic_phase_controller;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic [2:0] ext_req = '0;
  logic [2:0] ped_req = '0;
  logic       preempt_valid = 1'b0;
  logic [1:0] preempt_phase = '0;
  logic [5:0] light;
  logic [2:0] walk;
  logic [2:0] countdown;
  logic [4:0] seconds_left;
  logic [1:0] cur_phase;
  logic       tick;

  int checks = 0;
  int passes = 0;

  traffic_phase_controller #(
    .N_PHASES      (3),
    .PH_W          (2),
    .TICK_DIV      (4),
    .GREEN_SEC     (5),
    .EXT_SEC       (4),
    .YELLOW_SEC    (2),
    .ALLRED_SEC    (1),
    .COUNTDOWN_SEC (3),
    .CNT_W         (5)
  ) dut (
    .Clock         (Clock),
    .Resetn        (Resetn),
    .ext_req       (ext_req),
    .ped_req       (ped_req),
    .preempt_valid (preempt_valid),
    .preempt_phase (preempt_phase),
    .light         (light),
    .walk          (walk),
    .countdown     (countdown),
    .seconds_left  (seconds_left),
    .cur_phase     (cur_phase),
    .tick          (tick)
  );

  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish, passed=%0d total=%0d", passes, checks);
    $fatal(1);
  end

  // Counts negedges for which light keeps its current value; -1 on timeout.
  task automatic run_state(output int n);
    logic [5:0] l0;
    l0 = light;
    n = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clock);
      if (light !== l0) return;
      n++;
    end
    n = -1;
  endtask

  task automatic test_reset();
    int n;
    Resetn = 1'b0;
    repeat (2) @(negedge Clock);
    checks++; if (light !== 6'h00) $display("FAIL rst_light got %h exp 00", light); else passes++;
    checks++; if (walk !== 3'b000) $display("FAIL rst_walk got %b exp 000", walk); else passes++;
    checks++; if (countdown !== 3'b000) $display("FAIL rst_countdown got %b exp 000", countdown); else passes++;
    checks++; if (seconds_left !== 5'd1) $display("FAIL rst_secs got %0d exp 1", seconds_left); else passes++;
    checks++; if (cur_phase !== 2'd2) $display("FAIL rst_phase got %0d exp 2", cur_phase); else passes++;
    checks++; if (tick !== 1'b0) $display("FAIL rst_tick got %b exp 0", tick); else passes++;
    Resetn = 1'b1;
    run_state(n);
    checks++; if (n != 4) $display("FAIL first_allred_len got %0d exp 4", n); else passes++;
  endtask

  task automatic test_base_cycle();
    int n;
    checks++; if (light !== 6'h02) $display("FAIL p0_green_light got %h exp 02", light); else passes++;
    checks++; if (cur_phase !== 2'd0) $display("FAIL p0_phase got %0d exp 0", cur_phase); else passes++;
    checks++; if (seconds_left !== 5'd5) $display("FAIL p0_secs got %0d exp 5", seconds_left); else passes++;
    ped_req = 3'b100;
    @(negedge Clock);
    ped_req = 3'b000;
    checks++; if (walk !== 3'b000) $display("FAIL p0_no_walk got %b exp 000", walk); else passes++;
    run_state(n);
    checks++; if (n != 19) $display("FAIL p0_green_len got %0d exp 19", n); else passes++;
    checks++; if (light !== 6'h01) $display("FAIL p0_yellow_light got %h exp 01", light); else passes++;
    checks++; if (seconds_left !== 5'd2) $display("FAIL p0_yellow_secs got %0d exp 2", seconds_left); else passes++;
    run_state(n);
    checks++; if (n != 8) $display("FAIL p0_yellow_len got %0d exp 8", n); else passes++;
    checks++; if (light !== 6'h00) $display("FAIL p0_allred_light got %h exp 00", light); else passes++;
    ext_req = 3'b010;
    run_state(n);
    checks++; if (n != 4) $display("FAIL p0_allred_len got %0d exp 4", n); else passes++;
  endtask

  task automatic test_extension();
    int n;
    checks++; if (light !== 6'h08) $display("FAIL p1_green_light got %h exp 08", light); else passes++;
    checks++; if (cur_phase !== 2'd1) $display("FAIL p1_phase got %0d exp 1", cur_phase); else passes++;
    checks++; if (seconds_left !== 5'd9) $display("FAIL p1_ext_secs got %0d exp 9", seconds_left); else passes++;
    ext_req = 3'b000;
    run_state(n);
    checks++; if (n != 36) $display("FAIL p1_green_len got %0d exp 36", n); else passes++;
    checks++; if (light !== 6'h04) $display("FAIL p1_yellow_light got %h exp 04", light); else passes++;
    run_state(n);
    checks++; if (n != 8) $display("FAIL p1_yellow_len got %0d exp 8", n); else passes++;
    run_state(n);
    checks++; if (n != 4) $display("FAIL p1_allred_len got %0d exp 4", n); else passes++;
  endtask

  task automatic test_ped_walk();
    int n;
    logic [4:0] exp_s;
    logic [2:0] exp_walk;
    logic [2:0] exp_cd;
    logic       exp_tick;
    checks++; if (light !== 6'h20) $display("FAIL p2_green_light got %h exp 20", light); else passes++;
    checks++; if (cur_phase !== 2'd2) $display("FAIL p2_phase got %0d exp 2", cur_phase); else passes++;
    for (int k = 0; k < 20; k++) begin
      exp_s    = 5'(5 - k / 4);
      exp_walk = (exp_s > 5'd3) ? 3'b100 : 3'b000;
      exp_cd   = (exp_s <= 5'd3) ? 3'b100 : 3'b000;
      exp_tick = ((k % 4) == 3);
      checks++; if (seconds_left !== exp_s) $display("FAIL ped_secs k=%0d got %0d exp %0d", k, seconds_left, exp_s); else passes++;
      checks++; if (walk !== exp_walk) $display("FAIL ped_walk k=%0d got %b exp %b", k, walk, exp_walk); else passes++;
      checks++; if (countdown !== exp_cd) $display("FAIL ped_countdown k=%0d got %b exp %b", k, countdown, exp_cd); else passes++;
      checks++; if (tick !== exp_tick) $display("FAIL ped_tick k=%0d got %b exp %b", k, tick, exp_tick); else passes++;
      @(negedge Clock);
    end
    checks++; if (light !== 6'h10) $display("FAIL p2_yellow_light got %h exp 10", light); else passes++;
    checks++; if (walk !== 3'b000) $display("FAIL p2_yellow_walk got %b exp 000", walk); else passes++;
    checks++; if (countdown !== 3'b000) $display("FAIL p2_yellow_cd got %b exp 000", countdown); else passes++;
    run_state(n);
    checks++; if (n != 8) $display("FAIL p2_yellow_len got %0d exp 8", n); else passes++;
    run_state(n);
    checks++; if (n != 4) $display("FAIL p2_allred_len got %0d exp 4", n); else passes++;
  endtask

  task automatic test_preempt_skip();
    int n;
    checks++; if (light !== 6'h02) $display("FAIL pre_p0_light got %h exp 02", light); else passes++;
    checks++; if (cur_phase !== 2'd0) $display("FAIL pre_p0_phase got %0d exp 0", cur_phase); else passes++;
    repeat (4) @(negedge Clock);
    checks++; if (seconds_left !== 5'd4) $display("FAIL pre_secs got %0d exp 4", seconds_left); else passes++;
    preempt_valid = 1'b1;
    preempt_phase = 2'd2;
    @(negedge Clock);
    checks++; if (light !== 6'h01) $display("FAIL pre_yellow_light got %h exp 01", light); else passes++;
    checks++; if (seconds_left !== 5'd2) $display("FAIL pre_yellow_secs got %0d exp 2", seconds_left); else passes++;
    run_state(n);
    checks++; if (n != 8) $display("FAIL pre_yellow_len got %0d exp 8", n); else passes++;
    checks++; if (light !== 6'h00) $display("FAIL pre_allred_light got %h exp 00", light); else passes++;
    run_state(n);
    checks++; if (n != 4) $display("FAIL pre_allred_len got %0d exp 4", n); else passes++;
    checks++; if (light !== 6'h20) $display("FAIL pre_target_light got %h exp 20", light); else passes++;
    checks++; if (cur_phase !== 2'd2) $display("FAIL pre_target_phase got %0d exp 2", cur_phase); else passes++;
    preempt_valid = 1'b0;
    checks++; if (walk !== 3'b000) $display("FAIL pre_target_walk got %b exp 000", walk); else passes++;
    run_state(n);
    checks++; if (n != 20) $display("FAIL pre_target_green_len got %0d exp 20", n); else passes++;
    run_state(n);
    checks++; if (n != 8) $display("FAIL post_yellow_len got %0d exp 8", n); else passes++;
    run_state(n);
    checks++; if (n != 4) $display("FAIL post_allred_len got %0d exp 4", n); else passes++;
  endtask

  task automatic test_preempt_hold();
    int n;
    checks++; if (light !== 6'h02) $display("FAIL hold_p0_light got %h exp 02", light); else passes++;
    checks++; if (cur_phase !== 2'd0) $display("FAIL hold_p0_phase got %0d exp 0", cur_phase); else passes++;
    repeat (4) @(negedge Clock);
    checks++; if (seconds_left !== 5'd4) $display("FAIL hold_start_secs got %0d exp 4", seconds_left); else passes++;
    preempt_valid = 1'b1;
    preempt_phase = 2'd0;
    for (int h = 0; h < 10; h++) begin
      @(negedge Clock);
      checks++; if (seconds_left !== 5'd4) $display("FAIL hold_secs h=%0d got %0d exp 4", h, seconds_left); else passes++;
      checks++; if (light !== 6'h02) $display("FAIL hold_light h=%0d got %h exp 02", h, light); else passes++;
    end
    preempt_valid = 1'b0;
    run_state(n);
    checks++; if (n != 16) $display("FAIL hold_resume_len got %0d exp 16", n); else passes++;
  endtask

  task automatic test_reset_mid_yellow();
    int n;
    checks++; if (light !== 6'h01) $display("FAIL ry_yellow_light got %h exp 01", light); else passes++;
    repeat (3) @(negedge Clock);
    #2;
    Resetn = 1'b0;
    #1;
    checks++; if (light !== 6'h00) $display("FAIL ry_light got %h exp 00", light); else passes++;
    checks++; if (seconds_left !== 5'd1) $display("FAIL ry_secs got %0d exp 1", seconds_left); else passes++;
    checks++; if (cur_phase !== 2'd2) $display("FAIL ry_phase got %0d exp 2", cur_phase); else passes++;
    checks++; if (walk !== 3'b000) $display("FAIL ry_walk got %b exp 000", walk); else passes++;
    checks++; if (countdown !== 3'b000) $display("FAIL ry_countdown got %b exp 000", countdown); else passes++;
    checks++; if (tick !== 1'b0) $display("FAIL ry_tick got %b exp 0", tick); else passes++;
    @(negedge Clock);
    Resetn = 1'b1;
    run_state(n);
    checks++; if (n != 4) $display("FAIL ry_allred_len got %0d exp 4", n); else passes++;
    checks++; if (light !== 6'h02) $display("FAIL ry_first_green got %h exp 02", light); else passes++;
    checks++; if (cur_phase !== 2'd0) $display("FAIL ry_first_phase got %0d exp 0", cur_phase); else passes++;
  endtask

  initial begin
    test_reset();
    test_base_cycle();
    test_extension();
    test_ped_walk();
    test_preempt_skip();
    test_preempt_hold();
    test_reset_mid_yellow();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Parametrised N-approach intersection controller, the next generation of the fixed two-direction traffic-light FSM. It sequences green, yellow and all-red phases round-robin over `N_PHASES` approaches. It adds green extension on car demand, latched pedestrian requests with walk and countdown outputs, and emergency preemption. It sits between the PS2/switch input decoding and the lights, crosswalk and HEX display datapaths.

## Interface
Parameters:
- `N_PHASES`, default 2: number of approaches; must be at least 2.
- `PH_W`, default `$clog2(N_PHASES)`: width of a phase index.
- `TICK_DIV`, default 50000000: `Clock` cycles per second.
- `GREEN_SEC`, default 10: base green duration in seconds.
- `EXT_SEC`, default 5: extra green seconds when demand is present.
- `YELLOW_SEC`, default 3: yellow duration in seconds.
- `ALLRED_SEC`, default 1: all-red duration in seconds.
- `COUNTDOWN_SEC`, default 5: length of the pedestrian countdown at the end of green. Must be less than `GREEN_SEC`.
- `CNT_W`, default 5: width of the seconds counter. Must hold `GREEN_SEC+EXT_SEC`.

Ports (clock and reset first):
- `Clock`, in, 1: system clock.
- `Resetn`, in, 1: asynchronous, active-low reset.
- `ext_req`, in, `N_PHASES`: car demand per approach; sampled at green entry.
- `ped_req`, in, `N_PHASES`: pedestrian request pulse or level per approach.
- `preempt_valid`, in, 1: emergency preemption request (level).
- `preempt_phase`, in, `PH_W`: approach to be served by preemption.
- `light`, out, `2*N_PHASES`: 2-bit colour per approach (RED/YELLOW/GREEN codes from the package).
- `walk`, out, `N_PHASES`: pedestrian walk indication.
- `countdown`, out, `N_PHASES`: pedestrian countdown active.
- `seconds_left`, out, `CNT_W`: seconds remaining in the current state.
- `cur_phase`, out, `PH_W`: approach currently owning the green/yellow.
- `tick`, out, 1: one-cycle pulse marking each elapsed second.

## Operation
States:
- ALLRED: all approaches show red.
- GREEN: approach `cur_phase` shows green; all others red.
- YELLOW: approach `cur_phase` shows yellow; all others red.

Transitions:
- GREEN→YELLOW→ALLRED→GREEN.
- At ALLRED exit, the next phase is chosen as follows:
  - If `preempt_valid` is high and `preempt_phase < N_PHASES`, the next phase is `preempt_phase`.
  - Otherwise the next phase is `(cur_phase+1) mod N_PHASES`.
  - `preempt_phase >= N_PHASES` is ignored everywhere.

Durations:
- On state entry `seconds_left` loads the duration: GREEN loads `GREEN_SEC`, or `GREEN_SEC+EXT_SEC` if `ext_req[phase]` is high on the entry edge; YELLOW loads `YELLOW_SEC`; ALLRED loads `ALLRED_SEC`.
- Each `tick` decrements `seconds_left`. A tick that arrives while `seconds_left==1` performs the transition instead and loads the next duration.

Pedestrians:
- `ped_req[i]` sets `ped_pend[i]`.
- On entry to GREEN for phase i, `ped_pend[i]` is copied to `ped_active` and then cleared.
- A `ped_req[i]` that arrives during phase i's own green is kept pending for that phase's next service.
- `walk[i]` = GREEN, i is the current phase, `ped_active`, and `seconds_left > COUNTDOWN_SEC`.
- `countdown[i]` = the same conditions, but with `seconds_left <= COUNTDOWN_SEC`.

Preemption:
- In GREEN, with `preempt_valid` high and `preempt_phase` different from the current phase: on the next edge, go to YELLOW and clear `ped_active`.
- In GREEN, with `preempt_phase` equal to the current phase: hold. The prescaler and `seconds_left` freeze and the pedestrian outputs are held.
- In YELLOW and ALLRED there is no interruption.
- If a preemption request and a green-expiry tick occur on the same edge, take the preemption path; the resulting state is YELLOW either way.

## Timing
- Reset values: state ALLRED; `seconds_left=ALLRED_SEC`; `cur_phase=N_PHASES-1`, so that the first green is phase 0; `light` all RED; `walk=0`, `countdown=0`, `tick=0`; `ped_pend=0`; prescaler 0.
- Prescaler:
  - Counts 0..`TICK_DIV-1`; `tick` is asserted when the count equals `TICK_DIV-1`.
  - It is cleared on every state transition, so every state lasts exactly duration×`TICK_DIV` cycles.
  - Preemption cuts green short; the following YELLOW and ALLRED states still last their full durations.
- All outputs are registered or decoded from registers. The state change and the new `light` value appear in the same cycle.
- Asserting `Resetn` low at any point returns the block to the reset values immediately, because the reset is asynchronous.

## Structure
- Package `traffic_pkg`: state enum (ALLRED, GREEN, YELLOW) and light codes (RED=2'b00, YELLOW=2'b01, GREEN=2'b10).
- Sub-module `second_prescaler`: parameter `TICK_DIV`; ports `Clock`, `Resetn`, `clear`, `hold`, `tick`.

## Test plan
Bench parameters: `N_PHASES=3`, `TICK_DIV=4`, `GREEN_SEC=5`, `EXT_SEC=4`, `YELLOW_SEC=2`, `ALLRED_SEC=1`, `COUNTDOWN_SEC=3`.

- Release reset with no requests → ALLRED for 4 cycles, then phase 0 GREEN for 20 cycles, YELLOW for 8, ALLRED for 4, then phase 1 GREEN; the sequence continues 2→0.
- `ext_req[1]=1` at phase 1 green entry → `seconds_left` loads 9 and green lasts 36 cycles.
- `ped_req[2]` pulse during phase 0 green → at phase 2 green: `walk[2]` is high while `seconds_left` is 5..4, then `countdown[2]` is high while it is 3..1, then both are 0 in YELLOW.
- `preempt_valid=1`, `preempt_phase=2` during phase 0 green with `seconds_left=4` → YELLOW on the next edge, then ALLRED, then phase 2 GREEN (phase 1 is skipped).
- `preempt_phase=0` held during phase 0 green → `seconds_left` frozen. Release preemption → countdown resumes from the frozen value.
- `Resetn` low mid-YELLOW → all outputs return to their reset values in the same cycle; the first green after release is phase 0.
